axi_slv_wr_ctrl: RTL and testbench
==================================

Name: axi_slv_wr_ctrl

Overview:
- AXI4 slave write-path controller; the stage directly downstream of the AXI interface bundle (slave side), in front of the dual-port memory.
- Consumes AW/W handshakes and drives B; one outstanding write transaction at a time.
- Generates per-beat word addresses for FIXED/INCR/WRAP bursts and drives the memory write port (we/addr/data/strobe).
- Flags illegal or out-of-range accesses with SLVERR.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data bus width; 32, 64 or 128.
- MEM_DEPTH, 1024, memory depth in DATA_W-wide words; power of two.

Ports:
- ACLK  input  1  global clock
- ARESET  input  1  asynchronous, active-high reset
- AW_VALID  input  1  write address valid
- AW_READY  output  1  write address ready
- AW_ADDR  input  ADDR_W  burst start byte address
- AW_SIZE  input  3  bytes per beat = 2**AW_SIZE
- AW_BURST  input  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
- AW_LEN  input  8  beats minus one
- W_VALID  input  1  write data valid
- W_READY  output  1  write data ready
- W_DATA  input  DATA_W  write data
- W_STRB  input  DATA_W/8  byte strobes
- W_LAST  input  1  final beat marker
- B_VALID  output  1  response valid
- B_READY  input  1  response ready
- B_RESP  output  2  0=OKAY, 2=SLVERR
- MEM_WE  output  1  memory write enable, one cycle per accepted beat
- MEM_ADDR  output  log2(MEM_DEPTH)  memory word address
- MEM_WDATA  output  DATA_W  memory write data
- MEM_WSTRB  output  DATA_W/8  memory byte enables

Behaviour:
- Reset (async assert, sync release): state=IDLE; AW_READY, W_READY, B_VALID, MEM_WE=0; B_RESP=0; MEM_ADDR/MEM_WDATA/MEM_WSTRB=0; beat counter and error flag cleared.
- Reset mid-burst discards the transaction; no B response is issued for it.
- All outputs are registered.
- FSM states:
  - IDLE: AW_READY=1, asserted from the first ACLK edge after reset release. On AW_VALID&AW_READY: latch ADDR/SIZE/BURST/LEN, beat count=0, evaluate errors, go to DATA. AW_READY drops the following cycle.
  - DATA: W_READY=1. On each W_VALID&W_READY, the next cycle has MEM_WE=1 with the current beat's word address, W_DATA and W_STRB (1-cycle write latency). Beat count increments. When the count reaches LEN, go to RESP and drop W_READY.
  - RESP: B_VALID=1 with B_RESP held stable until B_READY. On B_VALID&B_READY go to IDLE; AW_READY=1 the next cycle.
- Back-to-back bursts: minimum 1 idle cycle between B handshake and the next AW acceptance.
- Word address = byte address >> log2(DATA_W/8), truncated to log2(MEM_DEPTH) bits.
- Byte address update per beat:
  - FIXED: unchanged.
  - INCR: addr += 2**SIZE.
  - WRAP: addr = (addr & ~(total-1)) | ((addr + 2**SIZE) & (total-1)), where total = (LEN+1)*2**SIZE.
- Narrow transfers: W_STRB passes through unmodified; no lane steering.
- SLVERR conditions; each suppresses MEM_WE for the affected beats, and the burst still completes with all LEN+1 beats accepted:
  - AW_SIZE > log2(DATA_W/8): whole burst suppressed.
  - AW_BURST=3: whole burst suppressed.
  - WRAP with LEN not in {1,3,7,15}: whole burst suppressed.
  - A beat whose byte address >= MEM_DEPTH*DATA_W/8: that beat only suppressed; other beats write normally.
  - W_LAST=1 on a beat other than the last, or W_LAST=0 on the last beat: SLVERR; writes are not suppressed. Termination is by beat count only.
- A W beat arriving in IDLE or RESP is not accepted (W_READY=0). A W beat presented in the same cycle as its AW is accepted the cycle after AW acceptance.
- No 4KB-boundary check; addresses wrap modulo 2**ADDR_W.

Test Plan:
- INCR, AW_ADDR=0x10, SIZE=2, LEN=3, data 0xA0..0xA3, STRB=0xF, W_LAST on beat 3 -> MEM_ADDR 4,5,6,7; MEM_WE 4 pulses; B_RESP=0.
- WRAP, AW_ADDR=0x38, SIZE=2, LEN=3 -> MEM_ADDR 14,15,12,13; B_RESP=0.
- FIXED, AW_ADDR=0x20, LEN=2 -> MEM_ADDR 8 three times, last data wins; STRB=0x3 gives MEM_WSTRB=0x3.
- AW_BURST=3, LEN=1 -> 2 beats accepted, MEM_WE never asserted, B_RESP=2. Same result for SIZE=3 with DATA_W=32, and for WRAP with LEN=2.
- INCR, AW_ADDR=0xFF8, SIZE=2, LEN=3, MEM_DEPTH=1024 -> writes at words 1022,1023 only; B_RESP=2.
- B_READY held low 5 cycles -> B_VALID/B_RESP stable, AW_READY=0 throughout. Separately, ARESET pulsed mid-burst after beat 1 -> all outputs 0, no B, next burst completes normally.

Source files
------------

// File: rtl/axi_slv_wr_ctrl.sv
// axi_slv_wr_ctrl: AXI4 slave write-path controller, one burst in flight.
// Turns AW/W beats into registered memory writes and returns a B response.
module axi_slv_wr_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         AW_VALID,
    output logic                         AW_READY,
    input  logic [ADDR_W-1:0]            AW_ADDR,
    input  logic [2:0]                   AW_SIZE,
    input  logic [1:0]                   AW_BURST,
    input  logic [7:0]                   AW_LEN,
    input  logic                         W_VALID,
    output logic                         W_READY,
    input  logic [DATA_W-1:0]            W_DATA,
    input  logic [DATA_W/8-1:0]          W_STRB,
    input  logic                         W_LAST,
    output logic                         B_VALID,
    input  logic                         B_READY,
    output logic [1:0]                   B_RESP,
    output logic                         MEM_WE,
    output logic [$clog2(MEM_DEPTH)-1:0] MEM_ADDR,
    output logic [DATA_W-1:0]            MEM_WDATA,
    output logic [DATA_W/8-1:0]          MEM_WSTRB
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int MA_W    = $clog2(MEM_DEPTH);
    localparam int LIM_W   = ADDR_W + 1;

    localparam logic [LIM_W-1:0] MEM_BYTES = LIM_W'(MEM_DEPTH) << BYTE_SH;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                aw_ready_q, aw_ready_d;
    logic                w_ready_q, w_ready_d;
    logic                b_valid_q, b_valid_d;
    logic [1:0]          b_resp_q, b_resp_d;
    logic                mem_we_q, mem_we_d;
    logic [MA_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                sup_q, sup_d;
    logic                err_q, err_d;

    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;
    logic                wrap_len_ok;
    logic                aw_bad;
    logic [ADDR_W-1:0]   step;
    logic [ADDR_W-1:0]   total;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [MA_W-1:0]     word_addr;
    logic                beat_oob;
    logic                last_beat;
    logic                beat_err;

    assign aw_hs = AW_VALID & aw_ready_q;
    assign w_hs  = W_VALID & w_ready_q;
    assign b_hs  = B_READY & b_valid_q;

    // Burst-wide errors decided once, at address acceptance.
    always_comb begin
        wrap_len_ok = (AW_LEN == 8'd1) || (AW_LEN == 8'd3) ||
                      (AW_LEN == 8'd7) || (AW_LEN == 8'd15);
        aw_bad = (AW_SIZE > 3'(BYTE_SH)) ||
                 (AW_BURST == BURST_RSVD) ||
                 ((AW_BURST == BURST_WRAP) && !wrap_len_ok);
    end

    always_comb begin
        step      = ADDR_W'(1) << size_q;
        total     = ADDR_W'({1'b0, len_q} + 9'd1) << size_q;
        wrap_mask = total - ADDR_W'(1);
        addr_inc  = addr_q + step;
        unique case (burst_q)
            BURST_FIXED: addr_nxt = addr_q;
            BURST_INCR:  addr_nxt = addr_inc;
            BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) |
                                    (addr_inc & wrap_mask);
            default:     addr_nxt = addr_q;
        endcase
    end

    always_comb begin
        word_addr = MA_W'(addr_q >> BYTE_SH);
        beat_oob  = {1'b0, addr_q} >= MEM_BYTES;
        last_beat = cnt_q == len_q;
        beat_err  = beat_oob || (W_LAST != last_beat);
    end

    always_comb begin
        state_d     = state_q;
        aw_ready_d  = aw_ready_q;
        w_ready_d   = w_ready_q;
        b_valid_d   = b_valid_q;
        b_resp_d    = b_resp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        addr_d      = addr_q;
        size_d      = size_q;
        burst_d     = burst_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sup_d       = sup_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_hs) begin
                    state_d    = S_DATA;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    addr_d     = AW_ADDR;
                    size_d     = AW_SIZE;
                    burst_d    = AW_BURST;
                    len_d      = AW_LEN;
                    cnt_d      = 8'd0;
                    sup_d      = aw_bad;
                    err_d      = aw_bad;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    // Out-of-range beats are dropped individually.
                    mem_we_d    = !sup_q && !beat_oob;
                    mem_addr_d  = word_addr;
                    mem_wdata_d = W_DATA;
                    mem_wstrb_d = W_STRB;
                    cnt_d       = cnt_q + 8'd1;
                    addr_d      = addr_nxt;
                    err_d       = err_q | beat_err;
                    if (last_beat) begin
                        state_d   = S_RESP;
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_resp_d  = (err_q | beat_err) ? RESP_SLVERR
                                                       : RESP_OKAY;
                    end
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    state_d    = S_IDLE;
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            sup_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_ready_q  <= aw_ready_d;
            w_ready_q   <= w_ready_d;
            b_valid_q   <= b_valid_d;
            b_resp_q    <= b_resp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sup_q       <= sup_d;
            err_q       <= err_d;
        end
    end

    assign AW_READY  = aw_ready_q;
    assign W_READY   = w_ready_q;
    assign B_VALID   = b_valid_q;
    assign B_RESP    = b_resp_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WSTRB = mem_wstrb_q;

endmodule

// File: tb/tb_axi_slv_wr_ctrl.sv
// tb_axi_slv_wr_ctrl: directed and random bursts against a
// burst-level reference model of the write controller.
module tb_axi_slv_wr_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int STRB_W    = DATA_W / 8;
    localparam int MA_W      = 10;
    localparam int MEM_BYTES = MEM_DEPTH * STRB_W;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              AW_VALID = 1'b0;
    logic              AW_READY;
    logic [ADDR_W-1:0] AW_ADDR = '0;
    logic [2:0]        AW_SIZE = '0;
    logic [1:0]        AW_BURST = '0;
    logic [7:0]        AW_LEN = '0;
    logic              W_VALID = 1'b0;
    logic              W_READY;
    logic [DATA_W-1:0] W_DATA = '0;
    logic [STRB_W-1:0] W_STRB = '0;
    logic              W_LAST = 1'b0;
    logic              B_VALID;
    logic              B_READY = 1'b0;
    logic [1:0]        B_RESP;
    logic              MEM_WE;
    logic [MA_W-1:0]   MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [STRB_W-1:0] MEM_WSTRB;

    axi_slv_wr_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .AW_ADDR(AW_ADDR), .AW_SIZE(AW_SIZE),
        .AW_BURST(AW_BURST), .AW_LEN(AW_LEN),
        .W_VALID(W_VALID), .W_READY(W_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [MA_W-1:0]   a;
        logic [DATA_W-1:0] d;
        logic [STRB_W-1:0] s;
    } wr_t;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] wd[256];
    logic [STRB_W-1:0] ws[256];
    logic              wl[256];
    int                n_chk = 0;
    int                n_pass = 0;
    int                wr_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge ACLK) begin : mon
        wr_t e;
        if (MEM_WE) begin
            wr_cnt++;
            chk("mem_we_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_addr", MEM_ADDR, e.a);
                chk("mem_wdata", MEM_WDATA, e.d);
                chk("mem_wstrb", MEM_WSTRB, e.s);
            end
        end
    end

    // Beat addresses computed in closed form from the burst rules.
    task automatic model(input logic [31:0] start, input int size,
                         input int burst, input int len,
                         output logic [1:0] resp);
        logic [31:0] step, total, a;
        bit bad, err;
        wr_t w;
        step  = 32'd1 << size;
        total = (len + 1) * step;
        bad = (size > 2) || (burst == 3) ||
              (burst == 2 && !(len inside {1, 3, 7, 15}));
        err = bad;
        for (int i = 0; i <= len; i++) begin
            if (burst == 0) a = start;
            else if (burst == 1) a = start + i * step;
            else a = (start & ~(total - 1)) |
                     (((start & (total - 1)) + i * step) % total);
            if (wl[i] != (i == len)) err = 1;
            if (!bad) begin
                if (a >= MEM_BYTES) err = 1;
                else begin
                    w.a = MA_W'(a >> 2);
                    w.d = wd[i];
                    w.s = ws[i];
                    exp_q.push_back(w);
                end
            end
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic fill_seq(input int len, input int base,
                            input logic [STRB_W-1:0] s);
        for (int i = 0; i <= len; i++) begin
            wd[i] = DATA_W'(base + i);
            ws[i] = s;
            wl[i] = (i == len);
        end
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = STRB_W'($urandom);
            wl[i] = (i == len);
        end
        if ($urandom_range(7) == 0) begin
            int k = $urandom_range(len);
            wl[k] = ~wl[k];
        end
    endtask

    task automatic run_burst(input logic [31:0] start, input int size,
                             input int burst, input int len,
                             input int bdelay, input int abort_at,
                             output logic [1:0] got);
        logic [1:0] er;
        int t;
        got = 2'b00;
        model(start, size, burst, len, er);
        AW_VALID = 1'b1;
        AW_ADDR  = start;
        AW_SIZE  = 3'(size);
        AW_BURST = 2'(burst);
        AW_LEN   = 8'(len);
        W_VALID  = 1'b1;
        W_DATA   = wd[0];
        W_STRB   = ws[0];
        W_LAST   = wl[0];
        t = 0;
        while (!AW_READY && t < 50) begin @(negedge ACLK); t++; end
        chk("aw_ready_wait", AW_READY, 1);
        @(negedge ACLK);
        AW_VALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i > 0 && $urandom_range(3) == 0) begin
                W_VALID = 1'b0;
                @(negedge ACLK);
            end
            W_VALID = 1'b1;
            W_DATA  = wd[i];
            W_STRB  = ws[i];
            W_LAST  = wl[i];
            t = 0;
            while (!W_READY && t < 50) begin @(negedge ACLK); t++; end
            chk("w_ready_wait", W_READY, 1);
            @(negedge ACLK);
            if (i == abort_at) begin
                W_VALID = 1'b0;
                #2 ARESET = 1'b1;
                #1;
                chk("rst_aw_ready", AW_READY, 0);
                chk("rst_w_ready", W_READY, 0);
                chk("rst_b_valid", B_VALID, 0);
                chk("rst_b_resp", B_RESP, 0);
                chk("rst_mem_we", MEM_WE, 0);
                chk("rst_mem_addr", MEM_ADDR, 0);
                chk("rst_mem_wdata", MEM_WDATA, 0);
                chk("rst_mem_wstrb", MEM_WSTRB, 0);
                exp_q.delete();
                @(negedge ACLK);
                ARESET = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge ACLK);
                    chk("abort_no_b", B_VALID, 0);
                    chk("abort_aw_ready", AW_READY, 1);
                end
                return;
            end
        end
        W_VALID = 1'b0;
        W_LAST  = 1'b0;
        t = 0;
        while (!B_VALID && t < 50) begin @(negedge ACLK); t++; end
        chk("b_valid_wait", B_VALID, 1);
        for (int d = 0; d < bdelay; d++) begin
            chk("b_hold_valid", B_VALID, 1);
            chk("b_hold_resp", B_RESP, er);
            chk("b_hold_aw_ready", AW_READY, 0);
            @(negedge ACLK);
        end
        got = B_RESP;
        chk("b_resp", B_RESP, er);
        B_READY = 1'b1;
        @(negedge ACLK);
        B_READY = 1'b0;
        chk("b_drop", B_VALID, 0);
        chk("aw_ready_after_b", AW_READY, 1);
        chk("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [1:0] r;
        int w0, size, burst, len;
        logic [31:0] start;

        @(negedge ACLK);
        chk("reset_aw_ready", AW_READY, 0);
        chk("reset_w_ready", W_READY, 0);
        chk("reset_b_valid", B_VALID, 0);
        chk("reset_b_resp", B_RESP, 0);
        chk("reset_mem_we", MEM_WE, 0);
        chk("reset_mem_addr", MEM_ADDR, 0);
        chk("reset_mem_wdata", MEM_WDATA, 0);
        chk("reset_mem_wstrb", MEM_WSTRB, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("aw_ready_first_edge", AW_READY, 1);

        w0 = wr_cnt;
        fill_seq(3, 'hA0, 4'hF);
        run_burst(32'h10, 2, 1, 3, 0, -1, r);
        chk("incr_resp", r, 2'b00);
        chk("incr_nwr", wr_cnt - w0, 4);

        w0 = wr_cnt;
        fill_seq(3, 'hB0, 4'hF);
        run_burst(32'h38, 2, 2, 3, 0, -1, r);
        chk("wrap_resp", r, 2'b00);
        chk("wrap_nwr", wr_cnt - w0, 4);

        w0 = wr_cnt;
        fill_seq(2, 'hC0, 4'h3);
        run_burst(32'h20, 2, 0, 2, 0, -1, r);
        chk("fixed_resp", r, 2'b00);
        chk("fixed_nwr", wr_cnt - w0, 3);

        w0 = wr_cnt;
        fill_seq(1, 'hD0, 4'hF);
        run_burst(32'h40, 2, 3, 1, 0, -1, r);
        chk("rsvd_resp", r, 2'b10);
        chk("rsvd_nwr", wr_cnt - w0, 0);

        w0 = wr_cnt;
        fill_seq(1, 'hD4, 4'hF);
        run_burst(32'h40, 3, 1, 1, 0, -1, r);
        chk("bigsize_resp", r, 2'b10);
        chk("bigsize_nwr", wr_cnt - w0, 0);

        w0 = wr_cnt;
        fill_seq(2, 'hD8, 4'hF);
        run_burst(32'h40, 2, 2, 2, 0, -1, r);
        chk("wraplen_resp", r, 2'b10);
        chk("wraplen_nwr", wr_cnt - w0, 0);

        w0 = wr_cnt;
        fill_seq(3, 'hE0, 4'hF);
        run_burst(32'hFF8, 2, 1, 3, 0, -1, r);
        chk("oob_resp", r, 2'b10);
        chk("oob_nwr", wr_cnt - w0, 2);

        w0 = wr_cnt;
        fill_seq(1, 'hF0, 4'hF);
        run_burst(32'h100, 2, 1, 1, 5, -1, r);
        chk("stall_resp", r, 2'b00);
        chk("stall_nwr", wr_cnt - w0, 2);

        fill_seq(3, 'h50, 4'hF);
        run_burst(32'h200, 2, 1, 3, 0, 1, r);

        w0 = wr_cnt;
        fill_seq(3, 'h60, 4'hF);
        run_burst(32'h300, 2, 1, 3, 0, -1, r);
        chk("post_rst_resp", r, 2'b00);
        chk("post_rst_nwr", wr_cnt - w0, 4);

        for (int n = 0; n < 60; n++) begin
            size  = ($urandom_range(7) == 0) ? 3 : $urandom_range(2);
            burst = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
            if (burst == 2 && $urandom_range(4) != 0)
                len = (2 << $urandom_range(3)) - 1;
            else
                len = $urandom_range(12);
            start = $urandom_range(4200);
            fill_rand(len);
            run_burst(start, size, burst, len, $urandom_range(3), -1, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
